pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the per-stage register enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Resolves load-use hazards, taken-branch flushes, instruction-fetch wait, data-memory wait and multi-cycle mul/div occupancy. A small FSM holds multi-cycle waits; a watchdog flags a hung data-memory handshake.

Parameters:
WAIT_TIMEOUT, 255, max consecutive MEM_WAIT cycles before timeout_err sets (1..65535)
CNT_W, 32, width of perf counters (used only with PIPE_CTRL_PERF_EN)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous reset, active-high
id_rs1  in  5  source reg 1 of instruction in ID
id_rs2  in  5  source reg 2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination reg of instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_reg_write  in  1  EX instruction writes rd
ex_branch_taken  in  1  branch/jump resolved taken in EX
ex_md_start  in  1  EX holds a mul/div op, first EX cycle
md_done  in  1  mul/div result valid this cycle
dmem_req  in  1  MEM stage has an active data access
dmem_ready  in  1  data memory completes access this cycle
imem_ready  in  1  instruction word valid this cycle
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID enable
id_ex_en  out  1  ID/EX enable
ex_mem_en  out  1  EX/MEM enable
mem_wb_en  out  1  MEM/WB enable
if_id_flush  out  1  load bubble into IF/ID
id_ex_flush  out  1  load bubble into ID/EX
ex_mem_flush  out  1  load bubble into EX/MEM
timeout_err  out  1  sticky, data-memory wait exceeded WAIT_TIMEOUT
stall_cycles  out  CNT_W  perf counter
flush_events  out  CNT_W  perf counter

Behaviour:
- Outputs are combinational from state and current inputs (Mealy); flush wins over enable at the pipeline register.
- While rst=1: all enables 0, all flushes 0. On the first clk with rst=1: state=RUN, wait counter=0, timeout_err=0, perf counters=0. Reset mid-wait aborts the wait.
- States: RUN, MEM_WAIT, MD_WAIT.
- Priority, highest first: mem wait > md wait > branch flush > load-use > imem wait.
- RUN, default: all enables 1, flushes 0.
- RUN, dmem_req=1 & dmem_ready=0:
  - All five enables 0 in the same cycle.
  - Next state MEM_WAIT.
- MEM_WAIT:
  - All enables 0; wait counter increments each cycle.
  - When dmem_ready=1: all enables 1 that cycle, counter cleared, next state RUN. The RUN rules re-evaluate on the following cycle.
  - When counter reaches WAIT_TIMEOUT: timeout_err sets and stays until rst. The FSM keeps waiting.
- RUN, ex_md_start=1 (no mem wait):
  - pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1, mem_wb_en=1.
  - Next state MD_WAIT. If md_done=1 in the same cycle, treat as single-cycle: normal RUN outputs, stay RUN.
- MD_WAIT:
  - Same outputs as the start cycle until md_done=1.
  - On md_done: all enables 1, next state RUN.
  - A dmem wait arriving in MD_WAIT freezes all enables that cycle, MEM wait priority. The FSM stays MD_WAIT; md_done is not lost because the divider holds it until its result is accepted.
- Branch flush, RUN, ex_branch_taken=1: all enables 1, if_id_flush=1, id_ex_flush=1. Load-use is ignored in that cycle.
- Load-use, RUN: all four terms true:
  - ex_is_load & ex_reg_write & ex_rd!=0
  - (id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)
  - Outputs: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1. Exactly one bubble, because the load leaves EX next cycle.
- Imem wait, RUN, imem_ready=0, no higher event: pc_en=0, if_id_flush=1, others 1. If a load-use also applies, load-use outputs take precedence, with pc_en=0 and IF/ID held rather than flushed.
- x0 never creates a hazard.

Optional Feature:
PIPE_CTRL_PERF_EN.
- Defined: stall_cycles increments every non-reset cycle in which pc_en=0.
- Defined: flush_events increments once per cycle in which any flush output is 1.
- Both counters saturate at all-ones.
- Not defined: both counter outputs tied to 0 and no counter flops are built.

Test Plan:
- Load-use: ex_is_load=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1.
- ex_rd=0 with a matching rs1=0 -> no stall, all enables 1.
- Taken branch concurrent with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_events+1 if the macro is defined.
- dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 cycles all enables 0, 4th cycle all enables 1; with the macro, stall_cycles=3.
- WAIT_TIMEOUT=4, dmem_ready held 0 for 10 cycles -> timeout_err rises after 4 wait cycles and stays 1 until rst.
- ex_md_start, md_done after 5 cycles; rst asserted on cycle 3 of a separate run -> ex_mem_flush=1 for 5 cycles then RUN; the reset run returns to RUN with all outputs at reset values.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: signal bundle between the pipeline datapath and the
// stall/flush sequencer.
//   master - datapath side: drives hazard/handshake status, receives controls
//   slave  - sequencer side: receives status, drives enables/flushes/status
// Parameter CNT_W sets the perf counter width and must match the sequencer.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_is_load;
    logic             ex_reg_write;
    logic             ex_branch_taken;
    logic             ex_md_start;
    logic             md_done;
    logic             dmem_req;
    logic             dmem_ready;
    logic             imem_ready;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load, ex_reg_write,
               ex_branch_taken, ex_md_start, md_done, dmem_req, dmem_ready, imem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
               ex_mem_flush, timeout_err, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load, ex_reg_write,
               ex_branch_taken, ex_md_start, md_done, dmem_req, dmem_ready, imem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
               ex_mem_flush, timeout_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Drives PC, IF/ID, ID/EX, EX/MEM, MEM/WB enables and flushes (Mealy outputs).
// Priority: data-mem wait > mul/div wait > taken branch > load-use > imem wait.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset (forces all enables/flushes low)
//   bus - pipe_hazard_ctrl_if.slave: hazard status in, enables/flushes,
//         timeout_err (sticky watchdog) and perf counters out
// Parameters: WAIT_TIMEOUT (1..65535) stalled data-mem cycles before
//   timeout_err; CNT_W perf counter width.
// Optional macro PIPE_CTRL_PERF_EN builds the saturating stall_cycles and
//   flush_events counters; otherwise they read as zero.
module pipe_hazard_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StRun, StMemWait, StMdWait} state_e;

    localparam logic [15:0] TimeoutVal = 16'(WAIT_TIMEOUT);

    // Enable order: {pc, if_id, id_ex, ex_mem, mem_wb}; flush order: {if_id, id_ex, ex_mem}
    localparam logic [4:0] EnAll    = 5'b11111;
    localparam logic [4:0] EnFreeze = 5'b00000;
    localparam logic [4:0] EnMd     = 5'b00011;
    localparam logic [4:0] EnLoadUs = 5'b00111;
    localparam logic [4:0] EnImem   = 5'b01111;

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic [4:0]  en;
    logic [2:0]  fl;
    logic        load_use;
    logic        mem_stall;
    logic        md_busy;

    always_comb begin
        load_use = bus.ex_is_load & bus.ex_reg_write & (bus.ex_rd != 5'd0) &
                   ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                    (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));
        // In MEM_WAIT only dmem_ready matters; elsewhere a new unfinished access stalls.
        mem_stall = (state_q == StMemWait) ? ~bus.dmem_ready : (bus.dmem_req & ~bus.dmem_ready);
        md_busy   = bus.ex_md_start & ~bus.md_done;
    end

    always_comb begin
        state_d = state_q;
        en      = EnAll;
        fl      = 3'b000;
        if (rst) begin
            en      = EnFreeze;
            state_d = StRun;
        end else begin
            unique case (state_q)
                StMemWait: begin
                    if (bus.dmem_ready) begin
                        state_d = StRun;
                    end else begin
                        en = EnFreeze;
                    end
                end
                StMdWait: begin
                    // A mem stall freezes everything; md_done stays held by the divider.
                    if (mem_stall) begin
                        en = EnFreeze;
                    end else if (bus.md_done) begin
                        state_d = StRun;
                    end else begin
                        en = EnMd;
                        fl = 3'b001;
                    end
                end
                StRun: begin
                    if (mem_stall) begin
                        en      = EnFreeze;
                        state_d = StMemWait;
                    end else if (md_busy) begin
                        en      = EnMd;
                        fl      = 3'b001;
                        state_d = StMdWait;
                    end else if (bus.ex_branch_taken) begin
                        fl = 3'b110;
                    end else if (load_use) begin
                        // Also covers a concurrent imem wait: IF/ID is held, not flushed.
                        en = EnLoadUs;
                        fl = 3'b010;
                    end else if (!bus.imem_ready) begin
                        en = EnImem;
                        fl = 3'b100;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        if (mem_stall) begin
            wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
        end else begin
            wait_cnt_d = 16'd0;
        end
        timeout_d = timeout_q | (wait_cnt_d >= TimeoutVal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            wait_cnt_q <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.pc_en        = en[4];
    assign bus.if_id_en     = en[3];
    assign bus.id_ex_en     = en[2];
    assign bus.ex_mem_en    = en[1];
    assign bus.mem_wb_en    = en[0];
    assign bus.if_id_flush  = fl[2];
    assign bus.id_ex_flush  = fl[1];
    assign bus.ex_mem_flush = fl[0];
    assign bus.timeout_err  = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!en[4] && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if ((fl != 3'b000) && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_events = flush_q;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
    assign bus.flush_events = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle vectors,
// hand-written multi-cycle sequences, then random stimulus against a
// priority-rule reference model.
module tb_pipe_hazard_ctrl;
    localparam int unsigned TO = 4;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output vector order: {pc, if_id, id_ex, ex_mem, mem_wb, f_if_id, f_id_ex, f_ex_mem}
    localparam logic [7:0] O_ALL = 8'b11111_000;
    localparam logic [7:0] O_LU  = 8'b00111_010;
    localparam logic [7:0] O_BR  = 8'b11111_110;
    localparam logic [7:0] O_IM  = 8'b01111_100;
    localparam logic [7:0] O_MD  = 8'b00011_001;
    localparam logic [7:0] O_FRZ = 8'b00000_000;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       rw;
        logic       br;
        logic       mds;
        logic       mdd;
        logic       dreq;
        logic       drdy;
        logic       irdy;
    } vin_t;

    typedef struct {
        string      name;
        vin_t       v;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

    pipe_hazard_ctrl #(
        .WAIT_TIMEOUT(TO),
        .CNT_W       (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_mem;   // waiting on data memory
    bit          m_md;    // waiting on mul/div
    int unsigned m_wait;
    bit          m_to;
    longint      m_stall;
    longint      m_flush;

    function automatic bit stall_now();
        if (m_mem) return !bus.dmem_ready;
        return bus.dmem_req && !bus.dmem_ready;
    endfunction

    function automatic bit lu_hit();
        bit m1, m2;
        m1 = bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd);
        m2 = bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd);
        return bus.ex_is_load && bus.ex_reg_write && (bus.ex_rd != 0) && (m1 || m2);
    endfunction

    // Expected outputs from the priority list, highest first.
    function automatic logic [7:0] model_out();
        if (rst) return 8'h00;
        if (m_mem) return bus.dmem_ready ? O_ALL : O_FRZ;
        if (stall_now()) return O_FRZ;
        if (m_md) return bus.md_done ? O_ALL : O_MD;
        if (bus.ex_md_start && !bus.md_done) return O_MD;
        if (bus.ex_branch_taken) return O_BR;
        if (lu_hit()) return O_LU;
        if (!bus.imem_ready) return O_IM;
        return O_ALL;
    endfunction

    always @(posedge clk) begin : model_seq
        bit          s;
        logic [7:0]  o;
        int unsigned w;
        s = stall_now();
        o = model_out();
        w = s ? m_wait + 1 : 0;
        if (rst) begin
            m_mem   <= 1'b0;
            m_md    <= 1'b0;
            m_wait  <= 0;
            m_to    <= 1'b0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            m_wait <= w;
            if (w >= TO) m_to <= 1'b1;
            if (m_mem) begin
                if (bus.dmem_ready) m_mem <= 1'b0;
            end else if (m_md) begin
                if (!s && bus.md_done) m_md <= 1'b0;
            end else if (s) begin
                m_mem <= 1'b1;
            end else if (bus.ex_md_start && !bus.md_done) begin
                m_md <= 1'b1;
            end
            if (!o[7]) m_stall <= m_stall + 1;
            if (o[2:0] != 3'b000) m_flush <= m_flush + 1;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [7:0] dut_out();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic apply(input vin_t v);
        bus.id_rs1          = v.rs1;
        bus.id_rs2          = v.rs2;
        bus.id_uses_rs1     = v.u1;
        bus.id_uses_rs2     = v.u2;
        bus.ex_rd           = v.rd;
        bus.ex_is_load      = v.ld;
        bus.ex_reg_write    = v.rw;
        bus.ex_branch_taken = v.br;
        bus.ex_md_start     = v.mds;
        bus.md_done         = v.mdd;
        bus.dmem_req        = v.dreq;
        bus.dmem_ready      = v.drdy;
        bus.imem_ready      = v.irdy;
    endtask

    // Check outputs mid-cycle, then advance to just after the next edge.
    task automatic step_chk(input string name, input logic [7:0] exp);
        @(negedge clk);
        chk(name, {56'd0, dut_out()}, {56'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vin_t base;
    vin_t v;
    vec_t tbl[12];

    task automatic do_reset();
        rst = 1'b1;
        apply(base);
        step_chk("rst_outs", 8'h00);
        @(negedge clk);
        chk("rst_timeout", {63'd0, bus.timeout_err}, 64'd0);
        chk("rst_stall_cnt", {32'd0, bus.stall_cycles}, 64'd0);
        chk("rst_flush_cnt", {32'd0, bus.flush_events}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        base = '{rs1: 5'd1, rs2: 5'd2, u1: 1'b1, u2: 1'b1, rd: 5'd3, ld: 1'b0, rw: 1'b1,
                 br: 1'b0, mds: 1'b0, mdd: 1'b0, dreq: 1'b0, drdy: 1'b0, irdy: 1'b1};
        for (int i = 0; i < 12; i++) tbl[i].v = base;
        tbl[0].name = "idle";       tbl[0].exp = O_ALL;
        tbl[1].name = "lu_rs1";     tbl[1].exp = O_LU;
        tbl[1].v.ld = 1; tbl[1].v.rd = 5; tbl[1].v.rs1 = 5;
        tbl[2].name = "lu_rs2";     tbl[2].exp = O_LU;
        tbl[2].v.ld = 1; tbl[2].v.rd = 7; tbl[2].v.rs2 = 7;
        tbl[3].name = "x0_no_haz";  tbl[3].exp = O_ALL;
        tbl[3].v.ld = 1; tbl[3].v.rd = 0; tbl[3].v.rs1 = 0;
        tbl[4].name = "lu_unused";  tbl[4].exp = O_ALL;
        tbl[4].v.ld = 1; tbl[4].v.rd = 5; tbl[4].v.rs1 = 5; tbl[4].v.u1 = 0;
        tbl[5].name = "lu_no_wr";   tbl[5].exp = O_ALL;
        tbl[5].v.ld = 1; tbl[5].v.rd = 5; tbl[5].v.rs1 = 5; tbl[5].v.rw = 0;
        tbl[6].name = "br_over_lu"; tbl[6].exp = O_BR;
        tbl[6].v.ld = 1; tbl[6].v.rd = 5; tbl[6].v.rs1 = 5; tbl[6].v.br = 1;
        tbl[7].name = "imem_wait";  tbl[7].exp = O_IM;
        tbl[7].v.irdy = 0;
        tbl[8].name = "imem_lu";    tbl[8].exp = O_LU;
        tbl[8].v.irdy = 0; tbl[8].v.ld = 1; tbl[8].v.rd = 5; tbl[8].v.rs1 = 5;
        tbl[9].name = "md_1cyc";    tbl[9].exp = O_ALL;
        tbl[9].v.mds = 1; tbl[9].v.mdd = 1;
        tbl[10].name = "dmem_hit";  tbl[10].exp = O_ALL;
        tbl[10].v.dreq = 1; tbl[10].v.drdy = 1;
        tbl[11].name = "alu_dep";   tbl[11].exp = O_ALL;
        tbl[11].v.rd = 5; tbl[11].v.rs1 = 5;

        apply(base);
        repeat (2) step();
        do_reset();

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].v);
            step_chk(tbl[i].name, tbl[i].exp);
        end

        // Load-use: exactly one bubble, then the load has left EX.
        v = tbl[1].v;
        apply(v);
        step_chk("lu_bubble", O_LU);
        apply(base);
        step_chk("lu_release", O_ALL);

        // Data-memory wait of three cycles.
        do_reset();
        v = base; v.dreq = 1;
        apply(v);
        for (int i = 0; i < 3; i++) step_chk("mem_wait", O_FRZ);
        v.drdy = 1;
        apply(v);
        step_chk("mem_done", O_ALL);
        apply(base);
        step_chk("mem_after", O_ALL);
        @(negedge clk);
        chk("mem_stall_cnt", {32'd0, bus.stall_cycles}, PERF ? 64'd3 : 64'd0);
        step();

        // Watchdog: sticky after TO stalled cycles, cleared only by reset.
        do_reset();
        v = base; v.dreq = 1;
        apply(v);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("to_rise", {63'd0, bus.timeout_err}, (k - 1 >= TO) ? 64'd1 : 64'd0);
            chk("to_frz", {56'd0, dut_out()}, {56'd0, O_FRZ});
            step();
        end
        v.drdy = 1;
        apply(v);
        step_chk("to_release", O_ALL);
        apply(base);
        step();
        @(negedge clk);
        chk("to_sticky", {63'd0, bus.timeout_err}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("to_cleared", {63'd0, bus.timeout_err}, 64'd0);
        step();

        // Branch over load-use bumps flush_events once.
        do_reset();
        apply(tbl[6].v);
        step_chk("br_lu_outs", O_BR);
        apply(base);
        @(negedge clk);
        chk("br_flush_cnt", {32'd0, bus.flush_events}, PERF ? 64'd1 : 64'd0);
        chk("br_stall_cnt", {32'd0, bus.stall_cycles}, 64'd0);
        step();

        // Mul/div: five flush cycles (branch ignored while waiting), then done.
        do_reset();
        v = base; v.mds = 1;
        apply(v);
        step_chk("md_start", O_MD);
        v.mds = 0;
        apply(v);
        step_chk("md_wait", O_MD);
        v.br = 1;
        apply(v);
        step_chk("md_wait_br", O_MD);
        v.br = 0;
        apply(v);
        repeat (2) step_chk("md_wait", O_MD);
        v.mdd = 1;
        apply(v);
        step_chk("md_done", O_ALL);
        apply(base);
        step_chk("md_run", O_ALL);

        // Mem stall during mul/div wait freezes but keeps waiting on md.
        v = base; v.mds = 1;
        apply(v);
        step_chk("md2_start", O_MD);
        v = base; v.dreq = 1; v.mdd = 1;
        apply(v);
        step_chk("md2_memfrz", O_FRZ);
        apply(base);
        step_chk("md2_still", O_MD);
        v = base; v.mdd = 1;
        apply(v);
        step_chk("md2_done", O_ALL);

        // Reset in the middle of a mul/div wait aborts it.
        do_reset();
        v = base; v.mds = 1;
        apply(v);
        step_chk("mdr_start", O_MD);
        v.mds = 0;
        apply(v);
        step_chk("mdr_wait", O_MD);
        rst = 1'b1;
        step_chk("mdr_rst", 8'h00);
        rst = 1'b0;
        apply(base);
        step_chk("mdr_run", O_ALL);

        // Random stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.rd   = 5'($urandom_range(0, 3));
            v.u1   = 1'($urandom_range(0, 1));
            v.u2   = 1'($urandom_range(0, 1));
            v.ld   = 1'($urandom_range(0, 1));
            v.rw   = ($urandom_range(0, 3) != 0);
            v.br   = ($urandom_range(0, 5) == 0);
            v.mds  = ($urandom_range(0, 3) == 0);
            v.mdd  = ($urandom_range(0, 3) == 0);
            v.dreq = ($urandom_range(0, 2) == 0);
            v.drdy = 1'($urandom_range(0, 1));
            v.irdy = ($urandom_range(0, 3) != 0);
            apply(v);
            rst = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            chk("rand_outs", {56'd0, dut_out()}, {56'd0, model_out()});
            chk("rand_timeout", {63'd0, bus.timeout_err}, {63'd0, m_to});
            chk("rand_stall_cnt", {32'd0, bus.stall_cycles}, PERF ? 64'(m_stall) : 64'd0);
            chk("rand_flush_cnt", {32'd0, bus.flush_events}, PERF ? 64'(m_flush) : 64'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
